// File: rtl/mem_bus_arbiter_if.sv
// Memory data bus bundle shared by the CPU core, DMA/debug loader and the MMU-fronted port.
// master drives the request (addr/wdata/access/len); slave returns rdata/ready/err.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        access;
  logic [1:0]        len;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;

  modport master (output addr, wdata, access, len, input rdata, ready, err);
  modport slave  (input addr, wdata, access, len, output rdata, ready, err);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the memory data bus; grant held per transaction.
// Optional slave-wait timeout enabled by defining MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                res,
  mem_bus_arbiter_if.slave    m0,
  mem_bus_arbiter_if.slave    m1,
  mem_bus_arbiter_if.master   s,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } ownerE;

  ownerE             owner, nextOwner;
  logic              last, nextLast;     // 1 = master 1 served last
  logic              req0, req1, ownerReq, done, timeoutHit;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic [1:0]        selAccess, selLen;

  // Ties go to the master that was not served last.
  function automatic ownerE pick(input logic r0, input logic r1, input logic lastM1);
    if (r0 && r1) return lastM1 ? OWN_M0 : OWN_M1;
    if (r0)       return OWN_M0;
    if (r1)       return OWN_M1;
    return OWN_NONE;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    selAddr   = '0;
    selWdata  = '0;
    selAccess = 2'b00;
    selLen    = 2'b00;
    ownerReq  = 1'b0;
    req0      = (m0.access != 2'b00);
    req1      = (m1.access != 2'b00);
    case (owner)
      OWN_M0: begin
        selAddr = m0.addr; selWdata = m0.wdata; selAccess = m0.access; selLen = m0.len;
        ownerReq = req0;
      end
      OWN_M1: begin
        selAddr = m1.addr; selWdata = m1.wdata; selAccess = m1.access; selLen = m1.len;
        ownerReq = req1;
      end
      default: ;
    endcase
    done = (owner != OWN_NONE) && (s.ready || s.err);
  end

  always_comb begin
    nextOwner = owner;
    nextLast  = last;
    if (owner == OWN_NONE) begin
      nextOwner = pick(req0, req1, last);
    end else if (done) begin
      // Re-arbitrate in the completion cycle so a waiting master sees no bubble.
      nextLast  = (owner == OWN_M1);
      nextOwner = pick(req0, req1, owner == OWN_M1);
    end else if (timeoutHit) begin
      nextLast  = (owner == OWN_M1);
      nextOwner = OWN_NONE;
    end else if (!ownerReq) begin
      nextOwner = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (res) begin
      owner <= OWN_NONE;
      last  <= 1'b1;
    end else begin
      owner <= nextOwner;
      last  <= nextLast;
    end
  end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? 16 : 8;
  logic [CNT_W-1:0] waitCnt;

  // waitCnt counts completed waiting cycles, so the TIMEOUT-th waiting cycle is the one that errors.
  assign timeoutHit = (owner != OWN_NONE) && !done && (waitCnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (res) begin
      waitCnt <= '0;
    end else if ((nextOwner != owner) || done) begin
      waitCnt <= '0;
    end else if (owner != OWN_NONE) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end
`else
  // Without the feature the arbiter waits indefinitely; the compare is constant false.
  assign timeoutHit = (TIMEOUT < 0);
`endif

  assign s.addr   = selAddr;
  assign s.wdata  = selWdata;
  assign s.access = timeoutHit ? 2'b00 : selAccess;
  assign s.len    = selLen;

  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;

  // Ready wins over err; nothing is reported while reset is asserted.
  assign m0.ready = (owner == OWN_M0) && s.ready && !res;
  assign m1.ready = (owner == OWN_M1) && s.ready && !res;
  assign m0.err   = (owner == OWN_M0) && !res && ((s.err && !s.ready) || timeoutHit);
  assign m1.err   = (owner == OWN_M1) && !res && ((s.err && !s.ready) || timeoutHit);

  assign grant = {owner == OWN_M1, owner == OWN_M0};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; inputs change 1ns after posedge, outputs
// are sampled on the falling edge.
module tb_mem_bus_arbiter;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic       clk;
  logic       res;
  logic [1:0] grant;
  int         nVectors;
  int         nMiscompares;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0Bus ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1Bus ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sBus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .res   (res),
    .m0    (m0Bus.slave),
    .m1    (m1Bus.slave),
    .s     (sBus.master),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clearAll();
    m0Bus.addr = '0; m0Bus.wdata = '0; m0Bus.access = 2'b00; m0Bus.len = 2'b00;
    m1Bus.addr = '0; m1Bus.wdata = '0; m1Bus.access = 2'b00; m1Bus.len = 2'b00;
    sBus.rdata = '0; sBus.ready = 1'b0; sBus.err = 1'b0;
  endtask

  task automatic doReset();
    tick();
    res = 1'b1;
    clearAll();
    tick();
    res = 1'b0;
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    res          = 1'b1;
    clearAll();

    // Reset state
    tick();
    sample();
    check("rst_grant",    grant,        2'b00);
    check("rst_s_access", sBus.access,  2'b00);
    check("rst_s_addr",   sBus.addr,    0);
    check("rst_m0_ready", m0Bus.ready,  1'b0);
    check("rst_m1_err",   m1Bus.err,    1'b0);

    // 1: single M0 read, slave ready on cycle 3
    tick();
    res = 1'b0;
    m0Bus.access = 2'b01; m0Bus.addr = 32'h8000_0000; m0Bus.len = 2'b10;
    sample();
    check("t1_c0_grant",    grant,       2'b00);
    check("t1_c0_s_access", sBus.access, 2'b00);
    tick(); sample();
    check("t1_c1_grant",    grant,       2'b01);
    check("t1_c1_s_addr",   sBus.addr,   32'h8000_0000);
    check("t1_c1_s_access", sBus.access, 2'b01);
    check("t1_c1_s_len",    sBus.len,    2'b10);
    tick(); sample();
    check("t1_c2_m0_ready", m0Bus.ready, 1'b0);
    tick();
    sBus.ready = 1'b1; sBus.rdata = 32'h1234_5678;
    sample();
    check("t1_c3_m0_ready", m0Bus.ready, 1'b1);
    check("t1_c3_m0_rdata", m0Bus.rdata, 32'h1234_5678);
    check("t1_c3_m1_ready", m1Bus.ready, 1'b0);
    m0Bus.access = 2'b00;
    tick();
    sBus.ready = 1'b0;
    sample();
    check("t1_c4_grant", grant, 2'b00);

    // 2: both request continuously; grants alternate with no idle cycle
    doReset();
    m0Bus.access = 2'b01; m0Bus.addr = 32'h0000_0100;
    m1Bus.access = 2'b01; m1Bus.addr = 32'h0000_0200;
    sample();
    check("t2_c0_grant", grant, 2'b00);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] expGrant;
      expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      sBus.ready = 1'b0;
      sample();
      check($sformatf("t2_x%0d_grant", k), grant, expGrant);
      check($sformatf("t2_x%0d_s_addr", k), sBus.addr,
            (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      tick();
      sBus.ready = 1'b1;
      sample();
      check($sformatf("t2_x%0d_grant_hold", k), grant, expGrant);
      check($sformatf("t2_x%0d_m0_ready", k), m0Bus.ready, expGrant[0]);
      check($sformatf("t2_x%0d_m1_ready", k), m1Bus.ready, expGrant[1]);
    end

    // 3: M1 byte write ends in slave error
    doReset();
    m1Bus.access = 2'b10; m1Bus.addr = 32'h0000_1000; m1Bus.wdata = 32'hDEAD_BEEF; m1Bus.len = 2'b00;
    sample();
    check("t3_c0_grant", grant, 2'b00);
    tick(); sample();
    check("t3_c1_grant",    grant,       2'b10);
    check("t3_c1_s_wdata",  sBus.wdata,  32'hDEAD_BEEF);
    check("t3_c1_s_addr",   sBus.addr,   32'h0000_1000);
    check("t3_c1_s_access", sBus.access, 2'b10);
    tick();
    sBus.err = 1'b1;
    sample();
    check("t3_c2_m1_err",   m1Bus.err,   1'b1);
    check("t3_c2_m1_ready", m1Bus.ready, 1'b0);
    check("t3_c2_m0_err",   m0Bus.err,   1'b0);
    m1Bus.access = 2'b00;
    tick();
    sBus.err = 1'b0;
    sample();
    check("t3_c3_grant",  grant,     2'b00);
    check("t3_c3_m1_err", m1Bus.err, 1'b0);

    // 4: M0 aborts while M1 waits
    doReset();
    m0Bus.access = 2'b01; m0Bus.addr = 32'h0000_0040;
    sample();
    tick(); sample();
    check("t4_c1_grant",    grant,       2'b01);
    check("t4_c1_s_access", sBus.access, 2'b01);
    tick();
    m0Bus.access = 2'b00;
    m1Bus.access = 2'b01; m1Bus.addr = 32'h0000_2000;
    sample();
    check("t4_c2_s_access", sBus.access, 2'b00);
    check("t4_c2_m0_ready", m0Bus.ready, 1'b0);
    check("t4_c2_m0_err",   m0Bus.err,   1'b0);
    tick(); sample();
    check("t4_c3_grant", grant, 2'b00);
    tick(); sample();
    check("t4_c4_grant",  grant,     2'b10);
    check("t4_c4_s_addr", sBus.addr, 32'h0000_2000);

    // 5: reset while M1 owns; slave ready during reset must not reach M1
    tick();
    res = 1'b1;
    sBus.ready = 1'b1;
    sample();
    check("t5_rst_m1_ready", m1Bus.ready, 1'b0);
    check("t5_rst_m1_err",   m1Bus.err,   1'b0);
    tick();
    res = 1'b0;
    sBus.ready = 1'b0;
    m0Bus.access = 2'b01; m0Bus.addr = 32'h0000_0080;
    sample();
    check("t5_c0_grant",    grant,       2'b00);
    check("t5_c0_s_access", sBus.access, 2'b00);
    check("t5_c0_s_addr",   sBus.addr,   0);
    tick(); sample();
    check("t5_c1_grant",  grant,     2'b01);
    check("t5_c1_s_addr", sBus.addr, 32'h0000_0080);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // 6: slave never answers M0; error on the 4th waiting cycle, then M1 served
    doReset();
    m0Bus.access = 2'b01; m0Bus.addr = 32'h0000_0300;
    m1Bus.access = 2'b01; m1Bus.addr = 32'h0000_0400;
    sample();
    for (int w = 1; w <= 3; w++) begin
      tick(); sample();
      check($sformatf("t6_w%0d_m0_err", w), m0Bus.err, 1'b0);
      check($sformatf("t6_w%0d_grant", w),  grant,     2'b01);
    end
    tick(); sample();
    check("t6_w4_m0_err",   m0Bus.err,   1'b1);
    check("t6_w4_s_access", sBus.access, 2'b00);
    m0Bus.access = 2'b00;
    tick(); sample();
    check("t6_after_grant", grant, 2'b00);
    tick(); sample();
    check("t6_m1_grant", grant, 2'b10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory data bus.
- Shares one memory/MMU port between master 0 (CPUCore data bus) and master 1 (DMA / debug loader).
- Round-robin grant, held per transaction until the slave completes with ready or error.
- Sits between the CPU/DMA and the MMU-fronted memory port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, slave-wait cycle limit (used only with MEM_BUS_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
res  input  1  reset, synchronous, active-high
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_access  input  2  master 0 MEM_ACCESS code; 2'b00 = NONE, other values are requests
m0_len  input  2  master 0 MEM_LEN code
m0_rdata  output  DATA_W  read data to master 0
m0_ready  output  1  master 0 transaction complete
m0_err  output  1  master 0 transaction aborted
m1_addr, m1_wdata, m1_access, m1_len, m1_rdata, m1_ready, m1_err  same widths and directions as the m0 ports, for master 1
s_addr  output  ADDR_W  slave address
s_wdata  output  DATA_W  slave write data
s_access  output  2  slave access code
s_len  output  2  slave length
s_rdata  input  DATA_W  slave read data
s_ready  input  1  slave complete
s_err  input  1  slave error (MMU exception)
grant  output  2  one-hot owner, 2'b00 = none

Behaviour:
- **State:** owner register (NONE / M0 / M1) and last-served bit.
- **Reset:**
  - owner=NONE, last=1, so M0 wins the first tie.
  - All outputs 0: s_access=2'b00, s_addr, s_wdata, s_len, m*_ready, m*_err, grant.
- **Request:** mX_access != 2'b00. Masters hold addr/access/len/wdata stable until ready or err.
- **Owner NONE:**
  - s_* driven to 0.
  - If any request is present, next owner is chosen at the clock edge:
    - single requester wins;
    - if both request, the master != last wins.
  - Grant latency is 1 cycle: request at cycle t, slave sees it at t+1. Minimum transaction is 2 cycles.
- **Owner MX:**
  - s_addr, s_wdata, s_access and s_len combinationally equal MX's signals.
  - mX_ready = s_ready; mX_err = s_err & ~s_ready (ready has priority).
  - The other master's ready/err = 0.
  - m0_rdata = m1_rdata = s_rdata (broadcast); only ready/err qualify the data.
- **Completion cycle** (s_ready | s_err while owner != NONE):
  - last <= owner.
  - Next owner is re-arbitrated in the same cycle using current requests, with the completing master treated as last.
  - Result: no bubble when the other master is waiting; the same master is re-granted if it alone requests.
- **Abort:** owner's access drops to 2'b00 before completion → owner <= NONE at that edge, last unchanged. Slave sees NONE combinationally that cycle.
- **Fairness:** with continuous requests from both masters, grants strictly alternate M0, M1, M0…
- **Spurious slave signals:** s_ready/s_err while owner NONE are ignored, with no master response.
- **Reset mid-transaction:** owner NONE next cycle, no ready/err issued. The slave must tolerate the withdrawn access.
- **Derived output:** grant = {owner==M1, owner==M0}.
- Expected size: 150–250 lines RTL.

Optional Feature:
MEM_BUS_ARB_TIMEOUT_EN
- **Defined:**
  - An 8..16-bit wait counter clears on every grant change and on completion, and increments each owned cycle without s_ready/s_err.
  - When the count equals TIMEOUT, the owner receives mX_err=1 for that cycle and s_access is forced to 2'b00.
  - owner <= NONE and last <= owner.
  - A slave response in the same cycle as the timeout wins and is a normal completion.
- **Undefined:** no counter; the arbiter waits indefinitely and TIMEOUT is ignored.

Test Plan:
1. Reset, then M0 access=R, addr 0x80000000, len W; s_ready at cycle 3 with s_rdata=0x12345678 → grant=01 from cycle 1; s_addr=0x80000000; m0_ready=1 and m0_rdata=0x12345678 at cycle 3; m1_ready=0 throughout.
2. Both masters request in the same cycle after reset; slave readies 1 cycle after each grant → grant sequence 01,10,01,10 with no NONE cycle between.
3. M1 write 0xDEADBEEF to 0x00001000 len B while M0 idle; s_err=1 and s_ready=0 → m1_err pulses 1 cycle, m1_ready=0, owner returns NONE next cycle.
4. M0 granted; M0 drops access to 00 before ready while M1 requests → s_access=00 that cycle; grant=00 then 10; no m0_ready/m0_err.
5. Assert res while M1 owns with a transaction pending → next cycle grant=00, all outputs 0; first request after reset with both masters requesting goes to M0.
6. (MEM_BUS_ARB_TIMEOUT_EN, TIMEOUT=4) M0 granted, slave never responds → m0_err=1 on the 4th waiting cycle; grant=00 next cycle; waiting M1 then granted.
